// File: rtl/slc3_mem_arbiter.sv
// rtl/slc3_mem_arbiter.sv - two-port round-robin SRAM arbiter and fixed-length access sequencer
module slc3_mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int WAIT   = 3
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Req0,
    input  logic              Req1,
    input  logic              We0,
    input  logic              We1,
    input  logic [ADDR_W-1:0] Addr0,
    input  logic [ADDR_W-1:0] Addr1,
    input  logic [DATA_W-1:0] Wdata0,
    input  logic [DATA_W-1:0] Wdata1,
    output logic              Ack0,
    output logic              Ack1,
    output logic [DATA_W-1:0] Rdata,
    output logic              Busy,
    output logic              Grant,
    output logic [ADDR_W-1:0] Mem_ADDR,
    output logic [DATA_W-1:0] Mem_Wdata,
    input  logic [DATA_W-1:0] Data_from_SRAM,
    output logic              Mem_OE,
    output logic              Mem_WE
);

    localparam int CNT_W = (WAIT > 1) ? $clog2(WAIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              grant_q, grant_d;
    logic              last_q, last_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              winner;

    // On a tie the port that did not win last time goes next.
    assign winner = (Req0 && Req1) ? ~last_q : Req1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        last_d  = last_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (Req0 || Req1) begin
                    state_d = ACCESS;
                    grant_d = winner;
                    last_d  = winner;
                    we_d    = winner ? We1 : We0;
                    addr_d  = winner ? Addr1 : Addr0;
                    wdata_d = winner ? Wdata1 : Wdata0;
                    cnt_d   = CNT_LOAD;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    if (!we_q) begin
                        rdata_d = Data_from_SRAM;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Every output is a register or a decode of registered state only.
    assign Busy      = (state_q != IDLE);
    assign Ack0      = (state_q == DONE) && !grant_q;
    assign Ack1      = (state_q == DONE) && grant_q;
    assign Mem_OE    = (state_q == ACCESS) && !we_q;
    assign Mem_WE    = (state_q == ACCESS) && we_q;
    assign Mem_ADDR  = addr_q;
    assign Mem_Wdata = wdata_q;
    assign Grant     = grant_q;
    assign Rdata     = rdata_q;

endmodule

// File: tb/tb_slc3_mem_arbiter.sv
// tb/tb_slc3_mem_arbiter.sv - directed and randomized checks of slc3_mem_arbiter against a schedule model
module tb_slc3_mem_arbiter;

    localparam int WAIT = 3;

    logic        Clk, Reset;
    logic        Req0, Req1, We0, We1;
    logic [15:0] Addr0, Addr1, Wdata0, Wdata1;
    logic        Ack0, Ack1, Busy, Grant, Mem_OE, Mem_WE;
    logic [15:0] Rdata, Mem_ADDR, Mem_Wdata, Data_from_SRAM;
    logic        Ack0_s, Ack1_s, Busy_s, Grant_s, Mem_OE_s, Mem_WE_s;
    logic [15:0] Rdata_s, Mem_ADDR_s, Mem_Wdata_s, Data_from_SRAM_s;

    int total = 0;
    int bad   = 0;

    logic [15:0] sram [256];
    logic        tb_wr_en;
    logic [7:0]  tb_wr_addr;
    logic [15:0] tb_wr_data;

    slc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT(WAIT)) dut (
        .Clk(Clk), .Reset(Reset), .Req0(Req0), .Req1(Req1), .We0(We0), .We1(We1),
        .Addr0(Addr0), .Addr1(Addr1), .Wdata0(Wdata0), .Wdata1(Wdata1),
        .Ack0(Ack0), .Ack1(Ack1), .Rdata(Rdata), .Busy(Busy), .Grant(Grant),
        .Mem_ADDR(Mem_ADDR), .Mem_Wdata(Mem_Wdata), .Data_from_SRAM(Data_from_SRAM),
        .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
    );

    slc3_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT(1)) dut_w1 (
        .Clk(Clk), .Reset(Reset), .Req0(Req0), .Req1(Req1), .We0(We0), .We1(We1),
        .Addr0(Addr0), .Addr1(Addr1), .Wdata0(Wdata0), .Wdata1(Wdata1),
        .Ack0(Ack0_s), .Ack1(Ack1_s), .Rdata(Rdata_s), .Busy(Busy_s), .Grant(Grant_s),
        .Mem_ADDR(Mem_ADDR_s), .Mem_Wdata(Mem_Wdata_s), .Data_from_SRAM(Data_from_SRAM_s),
        .Mem_OE(Mem_OE_s), .Mem_WE(Mem_WE_s)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk) begin
        if (tb_wr_en) sram[tb_wr_addr] <= tb_wr_data;
        else if (Mem_WE) sram[Mem_ADDR[7:0]] <= Mem_Wdata;
    end
    assign Data_from_SRAM   = sram[Mem_ADDR[7:0]];
    assign Data_from_SRAM_s = Mem_ADDR_s ^ 16'h5A5A;

    task automatic test_reset();
        logic [7:0]  pa [4];
        logic [15:0] pd [4];
        pa[0] = 8'h10; pd[0] = 16'h1234;
        pa[1] = 8'hFF; pd[1] = 16'hDEAD;
        pa[2] = 8'h50; pd[2] = 16'h5050;
        pa[3] = 8'h30; pd[3] = 16'h3333;
        Reset = 1'b1;
        for (int i = 0; i < 256; i++) begin
            tb_wr_en = 1'b1; tb_wr_addr = 8'(i); tb_wr_data = 16'(i * 257) ^ 16'h1357;
            @(negedge Clk);
        end
        for (int i = 0; i < 4; i++) begin
            tb_wr_en = 1'b1; tb_wr_addr = pa[i]; tb_wr_data = pd[i];
            @(negedge Clk);
        end
        tb_wr_en = 1'b0;
        total++;
        if ({Ack0, Ack1, Busy, Grant, Mem_OE, Mem_WE} !== 6'b0) begin
            bad++; $display("FAIL reset_ctrl: ack0/ack1/busy/grant/oe/we=%b want 000000", {Ack0, Ack1, Busy, Grant, Mem_OE, Mem_WE});
        end
        total++;
        if (Mem_ADDR !== 16'h0 || Mem_Wdata !== 16'h0 || Rdata !== 16'h0) begin
            bad++; $display("FAIL reset_data: addr=%h wdata=%h rdata=%h want 0 0 0", Mem_ADDR, Mem_Wdata, Rdata);
        end
        total++;
        if ({Busy_s, Ack0_s, Ack1_s} !== 3'b0 || Rdata_s !== 16'h0) begin
            bad++; $display("FAIL reset_w1: busy/ack0/ack1=%b rdata=%h want 000 0", {Busy_s, Ack0_s, Ack1_s}, Rdata_s);
        end
        Reset = 1'b0;
    endtask

    task automatic test_port0_read();
        Req0 = 1'b1; We0 = 1'b0; Addr0 = 16'h0010; Wdata0 = 16'h0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge Clk);
            total++;
            if (k <= 3) begin
                if ({Mem_OE, Mem_WE, Busy, Ack0, Ack1} !== 5'b10100 || Mem_ADDR !== 16'h0010 || Grant !== 1'b0) begin
                    bad++; $display("FAIL p0_read_access k=%0d: oe/we/busy/ack0/ack1=%b addr=%h grant=%b want 10100 0010 0", k, {Mem_OE, Mem_WE, Busy, Ack0, Ack1}, Mem_ADDR, Grant);
                end
            end else if (k == 4) begin
                if ({Mem_OE, Mem_WE, Busy, Ack0, Ack1} !== 5'b00110 || Rdata !== 16'h1234) begin
                    bad++; $display("FAIL p0_read_ack: oe/we/busy/ack0/ack1=%b rdata=%h want 00110 1234", {Mem_OE, Mem_WE, Busy, Ack0, Ack1}, Rdata);
                end
                Req0 = 1'b0;
            end else begin
                if ({Ack0, Ack1, Busy} !== 3'b000) begin
                    bad++; $display("FAIL p0_read_idle: ack0/ack1/busy=%b want 000", {Ack0, Ack1, Busy});
                end
            end
        end
    endtask

    task automatic test_port1_write();
        Req1 = 1'b1; We1 = 1'b1; Addr1 = 16'h0020; Wdata1 = 16'hBEEF;
        for (int k = 1; k <= 5; k++) begin
            @(negedge Clk);
            total++;
            if (k <= 3) begin
                if ({Mem_OE, Mem_WE, Busy, Ack0, Ack1} !== 5'b01100 || Mem_ADDR !== 16'h0020 || Mem_Wdata !== 16'hBEEF || Grant !== 1'b1) begin
                    bad++; $display("FAIL p1_write_access k=%0d: oe/we/busy/ack0/ack1=%b addr=%h wdata=%h grant=%b want 01100 0020 beef 1", k, {Mem_OE, Mem_WE, Busy, Ack0, Ack1}, Mem_ADDR, Mem_Wdata, Grant);
                end
            end else if (k == 4) begin
                if ({Mem_OE, Mem_WE, Busy, Ack0, Ack1} !== 5'b00101 || Rdata !== 16'h1234) begin
                    bad++; $display("FAIL p1_write_ack: oe/we/busy/ack0/ack1=%b rdata=%h want 00101 1234", {Mem_OE, Mem_WE, Busy, Ack0, Ack1}, Rdata);
                end
                Req1 = 1'b0;
            end else begin
                if ({Ack0, Ack1, Busy} !== 3'b000 || sram[8'h20] !== 16'hBEEF) begin
                    bad++; $display("FAIL p1_write_done: ack0/ack1/busy=%b sram=%h want 000 beef", {Ack0, Ack1, Busy}, sram[8'h20]);
                end
            end
        end
    endtask

    task automatic test_addr_change();
        Req0 = 1'b1; We0 = 1'b0; Addr0 = 16'h0010;
        for (int k = 1; k <= 4; k++) begin
            @(negedge Clk);
            total++;
            if (k <= 3) begin
                if (Mem_ADDR !== 16'h0010 || {Mem_OE, Mem_WE} !== 2'b10) begin
                    bad++; $display("FAIL addr_hold k=%0d: addr=%h oe/we=%b want 0010 10", k, Mem_ADDR, {Mem_OE, Mem_WE});
                end
                if (k == 2) begin
                    Addr0 = 16'h0FFF; We0 = 1'b1; Wdata0 = 16'hAAAA;
                end
            end else begin
                if (Ack0 !== 1'b1 || Rdata !== 16'h1234) begin
                    bad++; $display("FAIL addr_hold_ack: ack0=%b rdata=%h want 1 1234", Ack0, Rdata);
                end
                Req0 = 1'b0; We0 = 1'b0; Addr0 = 16'h0;
            end
        end
        @(negedge Clk);
    endtask

    task automatic test_round_robin();
        int ack_c[$];
        bit ack_p[$];
        Reset = 1'b1;
        Req0 = 1'b1; We0 = 1'b0; Addr0 = 16'h0010;
        Req1 = 1'b1; We1 = 1'b1; Addr1 = 16'h0040; Wdata1 = 16'h0101;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge Clk);
            if (Ack0 || Ack1) begin
                ack_c.push_back(c);
                ack_p.push_back(Ack1);
            end
        end
        Req0 = 1'b0; Req1 = 1'b0;
        total++;
        if (ack_c.size() != 4) begin
            bad++; $display("FAIL rr_count: acks=%0d want 4", ack_c.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (ack_c[i] != 4 + 5 * i || ack_p[i] !== 1'(i % 2)) begin
                    bad++; $display("FAIL rr_seq[%0d]: cycle=%0d port=%0d want cycle=%0d port=%0d", i, ack_c[i], ack_p[i], 4 + 5 * i, i % 2);
                end
            end
        end
        repeat (8) @(negedge Clk);
    endtask

    task automatic test_reset_abort();
        Req0 = 1'b1; We0 = 1'b0; Addr0 = 16'h0010;
        for (int k = 1; k <= 8; k++) begin
            @(negedge Clk);
            total++;
            if (k <= 2) begin
                if ({Mem_OE, Busy} !== 2'b11 || Rdata !== 16'h1234) begin
                    bad++; $display("FAIL abort_pre k=%0d: oe/busy=%b rdata=%h want 11 1234", k, {Mem_OE, Busy}, Rdata);
                end
                if (k == 1) begin
                    Req1 = 1'b1; We1 = 1'b0; Addr1 = 16'h0050;
                end else begin
                    Reset = 1'b1; Req0 = 1'b0;
                end
            end else if (k == 3) begin
                if ({Busy, Mem_OE, Mem_WE, Ack0, Ack1, Grant} !== 6'b0 || Rdata !== 16'h0) begin
                    bad++; $display("FAIL abort_reset: busy/oe/we/ack0/ack1/grant=%b rdata=%h want 000000 0", {Busy, Mem_OE, Mem_WE, Ack0, Ack1, Grant}, Rdata);
                end
                Reset = 1'b0;
            end else if (k <= 6) begin
                if ({Ack0, Ack1, Mem_OE} !== 3'b001 || Mem_ADDR !== 16'h0050 || Grant !== 1'b1) begin
                    bad++; $display("FAIL abort_pending k=%0d: ack0/ack1/oe=%b addr=%h grant=%b want 001 0050 1", k, {Ack0, Ack1, Mem_OE}, Mem_ADDR, Grant);
                end
            end else if (k == 7) begin
                if ({Ack0, Ack1} !== 2'b01 || Rdata !== 16'h5050) begin
                    bad++; $display("FAIL abort_pending_ack: ack0/ack1=%b rdata=%h want 01 5050", {Ack0, Ack1}, Rdata);
                end
                Req1 = 1'b0;
            end else begin
                if (Busy !== 1'b0) begin
                    bad++; $display("FAIL abort_idle: busy=%b want 0", Busy);
                end
            end
        end
    endtask

    task automatic test_wait1();
        int oe_n;
        oe_n = 0;
        Reset = 1'b1; Req0 = 1'b0; Req1 = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        Req0 = 1'b1; We0 = 1'b0; Addr0 = 16'h0030;
        for (int k = 1; k <= 5; k++) begin
            @(negedge Clk);
            if (Mem_OE_s) oe_n++;
            if (k == 1) begin
                total++;
                if (Busy_s !== 1'b1 || Mem_ADDR_s !== 16'h0030) begin
                    bad++; $display("FAIL w1_access: busy=%b addr=%h want 1 0030", Busy_s, Mem_ADDR_s);
                end
                Req0 = 1'b0;
            end else if (k == 2) begin
                total++;
                if ({Ack0_s, Ack1_s, Mem_OE_s} !== 3'b100 || Rdata_s !== 16'h5A6A) begin
                    bad++; $display("FAIL w1_ack: ack0/ack1/oe=%b rdata=%h want 100 5a6a", {Ack0_s, Ack1_s, Mem_OE_s}, Rdata_s);
                end
            end else if (k == 3) begin
                total++;
                if ({Ack0_s, Busy_s} !== 2'b00) begin
                    bad++; $display("FAIL w1_idle: ack0/busy=%b want 00", {Ack0_s, Busy_s});
                end
            end else if (k == 4) begin
                total++;
                if (Ack0 !== 1'b1 || Rdata !== 16'h3333) begin
                    bad++; $display("FAIL dropped_req_ack: ack0=%b rdata=%h want 1 3333", Ack0, Rdata);
                end
            end
        end
        total++;
        if (oe_n != 1) begin
            bad++; $display("FAIL w1_oe_len: oe cycles=%0d want 1", oe_n);
        end
    endtask

    task automatic test_random();
        logic [15:0] refmem [256];
        bit          m_busy, last, gp, gwe, in_acc, is_ack;
        int          gc, next_free;
        logic [15:0] ga, gwd, exp_rd;
        logic [4:0]  exp_v;
        Reset = 1'b1; Req0 = 1'b0; Req1 = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        for (int i = 0; i < 256; i++) refmem[i] = sram[i];
        m_busy = 0; last = 1; gp = 0; gwe = 0; gc = 0; next_free = 0;
        ga = '0; gwd = '0; exp_rd = '0;
        for (int c = 0; c < 800; c++) begin
            if (c > 0) @(negedge Clk);
            in_acc = m_busy && (c >= gc + 1) && (c <= gc + WAIT);
            is_ack = m_busy && (c == gc + WAIT + 1);
            if (is_ack) begin
                if (gwe) refmem[ga[7:0]] = gwd;
                else exp_rd = refmem[ga[7:0]];
            end
            exp_v = {is_ack && !gp, is_ack && gp, in_acc || is_ack, in_acc && !gwe, in_acc && gwe};
            total++;
            if ({Ack0, Ack1, Busy, Mem_OE, Mem_WE} !== exp_v) begin
                bad++; $display("FAIL rand_ctrl cyc=%0d: ack0/ack1/busy/oe/we=%b want %b", c, {Ack0, Ack1, Busy, Mem_OE, Mem_WE}, exp_v);
            end
            total++;
            if (Rdata !== exp_rd) begin
                bad++; $display("FAIL rand_rdata cyc=%0d: rdata=%h want %h", c, Rdata, exp_rd);
            end
            if (in_acc) begin
                total++;
                if (Mem_ADDR !== ga || Grant !== gp || (gwe && Mem_Wdata !== gwd)) begin
                    bad++; $display("FAIL rand_pins cyc=%0d: addr=%h wdata=%h grant=%b want %h %h %b", c, Mem_ADDR, Mem_Wdata, Grant, ga, gwd, gp);
                end
            end
            if (is_ack) m_busy = 0;
            if (Req0 && Ack0) Req0 = 1'b0;
            else if (Req0 && m_busy && !gp) begin
                if ($urandom_range(1) == 1) begin
                    Addr0 = 16'($urandom); Wdata0 = 16'($urandom); We0 = ~We0;
                end
            end else if (!Req0 && $urandom_range(2) == 0) begin
                Req0 = 1'b1; We0 = 1'($urandom_range(1)); Addr0 = 16'($urandom); Wdata0 = 16'($urandom);
            end
            if (Req1 && Ack1) Req1 = 1'b0;
            else if (Req1 && m_busy && gp) begin
                if ($urandom_range(1) == 1) begin
                    Addr1 = 16'($urandom); Wdata1 = 16'($urandom); We1 = ~We1;
                end
            end else if (!Req1 && $urandom_range(2) == 0) begin
                Req1 = 1'b1; We1 = 1'($urandom_range(1)); Addr1 = 16'($urandom); Wdata1 = 16'($urandom);
            end
            if (!m_busy && c >= next_free && (Req0 || Req1)) begin
                gp        = (Req0 && Req1) ? !last : Req1;
                gwe       = gp ? We1 : We0;
                ga        = gp ? Addr1 : Addr0;
                gwd       = gp ? Wdata1 : Wdata0;
                gc        = c;
                next_free = c + WAIT + 2;
                last      = gp;
                m_busy    = 1;
            end
        end
        Req0 = 1'b0; Req1 = 1'b0;
        repeat (WAIT + 3) @(negedge Clk);
    endtask

    initial begin
        Reset = 1'b1; Req0 = 1'b0; Req1 = 1'b0; We0 = 1'b0; We1 = 1'b0;
        Addr0 = '0; Addr1 = '0; Wdata0 = '0; Wdata1 = '0;
        tb_wr_en = 1'b0; tb_wr_addr = '0; tb_wr_data = '0;
        test_reset();
        test_port0_read();
        test_port1_write();
        test_addr_change();
        test_round_robin();
        test_reset_abort();
        test_wait1();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
